hsi_s_rx_frame_buf: RTL

Receive frame buffer directly downstream of the slave RX control stage. It takes the decoded byte stream, the frame-end strobe, the RX flag and the error vector. Complete error-free frames are committed into a circular byte RAM with a length/flag descriptor. Errored or overflowing frames are rolled back and counted. The host side pops committed frames byte-by-byte with a 1-cycle read latency.

---
 rtl/hsi_s_rx_frame_buf.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/hsi_s_rx_frame_buf.sv
// hsi_s_rx_frame_buf
//   Receive frame buffer behind the slave RX control stage. Bytes of the
//   current frame are written speculatively into a circular byte RAM. At
//   frame_end the frame is either committed, which pushes a {len, flag}
//   descriptor, or rolled back and counted as a drop. The host pops committed
//   frames byte by byte with a registered (1-cycle) read.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   d, d_rdy            received byte and its one-cycle valid strobe
//   frame_end           one-cycle strobe closing the current frame
//   rx_flag, rx_errs    frame flag / error vector, sampled at frame_end
//   rd_en               host requests the next byte of the head frame
//   frm_avail           at least one committed frame present
//   frm_len, frm_flag   head descriptor (0 when nothing is committed)
//   rd_data, rd_valid   read byte, one cycle after an accepted rd_en
//   rd_last             with rd_valid: final byte of the frame
//   drop, drop_reason   one-cycle discard pulse and its cause
//   drop_cnt            saturating count of discarded frames
module hsi_s_rx_frame_buf #(
  parameter int ADDR_W  = 8,
  parameter int DESC_W  = 2,
  parameter int MAX_LEN = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d,
  input  logic       d_rdy,
  input  logic       frame_end,
  input  logic [7:0] rx_flag,
  input  logic [5:0] rx_errs,
  input  logic       rd_en,
  output logic       frm_avail,
  output logic [7:0] frm_len,
  output logic [7:0] frm_flag,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rd_last,
  output logic       drop,
  output logic [1:0] drop_reason,
  output logic [7:0] drop_cnt
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam int              NDESC   = 1 << DESC_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [DESC_W:0] NDESC_V = (DESC_W+1)'(NDESC);
  localparam logic [7:0]      MAX_V   = 8'(MAX_LEN);

  localparam logic [1:0] RSN_ERR   = 2'd0;
  localparam logic [1:0] RSN_OVF   = 2'd1;
  localparam logic [1:0] RSN_DFULL = 2'd2;
  localparam logic [1:0] RSN_EMPTY = 2'd3;

  typedef enum logic {R_IDLE, R_BUSY} rstate_t;

  // storage
  logic [7:0] ram       [DEPTH];
  logic [7:0] desc_len  [NDESC];
  logic [7:0] desc_flag [NDESC];

  // write side
  logic [ADDR_W:0] wr_ptr, wr_tmp, rd_ptr, used, wr_tmp_nx;
  logic [7:0]      cur_len, len_nx;
  logic            ovf, ovf_now, full, byte_ok;
  logic            push, drop_c;
  logic [1:0]      rsn_c;

  // descriptor FIFO
  logic [DESC_W-1:0] dwr, drd;
  logic [DESC_W:0]   dcnt;
  logic              desc_full, pop;
  logic [7:0]        head_len;

  // read side
  rstate_t    state, state_nx;
  logic [7:0] rem, rem_nx, rem_eff;
  logic       rd_acc, rd_end;

  // ---------------------------------------------------------------------------
  // write-side decisions
  // ---------------------------------------------------------------------------
  assign used      = wr_tmp - rd_ptr;
  assign full      = (used == DEPTH_V);
  assign byte_ok   = d_rdy && !ovf && !full && (cur_len < MAX_V);
  // a byte refused this very cycle already taints a frame closing now
  assign ovf_now   = ovf || (d_rdy && !byte_ok);
  assign wr_tmp_nx = wr_tmp + {{ADDR_W{1'b0}}, byte_ok};
  assign len_nx    = cur_len + {7'd0, byte_ok};
  // a pop in the same cycle frees a slot, so a full FIFO can still take the push
  assign desc_full = (dcnt == NDESC_V);

  always_comb begin
    drop_c = 1'b0;
    rsn_c  = RSN_ERR;
    push   = 1'b0;
    if (frame_end) begin
      if (cur_len == 8'd0 && !d_rdy) begin
        drop_c = 1'b1;
        rsn_c  = RSN_EMPTY;
      end else if (rx_errs != 6'd0) begin
        drop_c = 1'b1;
        rsn_c  = RSN_ERR;
      end else if (ovf_now) begin
        drop_c = 1'b1;
        rsn_c  = RSN_OVF;
      end else if (desc_full && !pop) begin
        drop_c = 1'b1;
        rsn_c  = RSN_DFULL;
      end else begin
        push = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // read-side FSM
  // ---------------------------------------------------------------------------
  assign frm_avail = (dcnt != '0);
  assign head_len  = desc_len[drd];
  assign frm_len   = frm_avail ? head_len       : 8'd0;
  assign frm_flag  = frm_avail ? desc_flag[drd] : 8'd0;

  // in R_IDLE the remaining count is the head length itself, so the first
  // byte of a frame can be read in the same cycle the frame becomes the head
  assign rem_eff = (state == R_IDLE) ? head_len : rem;
  assign rd_acc  = rd_en && frm_avail;
  assign rd_end  = rd_acc && (rem_eff == 8'd1);
  assign pop     = rd_end;

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    case (state)
      R_IDLE: begin
        if (frm_avail) rem_nx = head_len;
        if (rd_acc && !rd_end) begin
          state_nx = R_BUSY;
          rem_nx   = rem_eff - 8'd1;
        end
      end
      R_BUSY: begin
        if (rd_end) begin
          state_nx = R_IDLE;
          rem_nx   = 8'd0;
        end else if (rd_acc) begin
          rem_nx = rem - 8'd1;
        end
      end
      default: state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= R_IDLE;
      rem   <= 8'd0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // storage writes (contents need no reset; pointers gate visibility)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (byte_ok) ram[wr_tmp[ADDR_W-1:0]] <= d;
    if (push) begin
      desc_len[dwr]  <= len_nx;
      desc_flag[dwr] <= rx_flag;
    end
  end

  // ---------------------------------------------------------------------------
  // pointers, counters, registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      wr_tmp      <= '0;
      rd_ptr      <= '0;
      cur_len     <= 8'd0;
      ovf         <= 1'b0;
      dwr         <= '0;
      drd         <= '0;
      dcnt        <= '0;
      drop        <= 1'b0;
      drop_reason <= 2'd0;
      drop_cnt    <= 8'd0;
      rd_data     <= 8'd0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
    end else begin
      if (frame_end) begin
        cur_len <= 8'd0;
        ovf     <= 1'b0;
        if (drop_c) begin
          wr_tmp <= wr_ptr;
        end else begin
          wr_tmp <= wr_tmp_nx;
          wr_ptr <= wr_tmp_nx;
        end
      end else if (byte_ok) begin
        wr_tmp  <= wr_tmp_nx;
        cur_len <= len_nx;
      end else if (d_rdy) begin
        ovf <= 1'b1;
      end

      drop <= drop_c;
      if (drop_c) begin
        drop_reason <= rsn_c;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end

      if (push) dwr <= dwr + 1'b1;
      if (pop)  drd <= drd + 1'b1;
      case ({push, pop})
        2'b10:   dcnt <= dcnt + 1'b1;
        2'b01:   dcnt <= dcnt - 1'b1;
        default: dcnt <= dcnt;
      endcase

      rd_valid <= rd_acc;
      rd_last  <= rd_end;
      if (rd_acc) begin
        rd_data <= ram[rd_ptr[ADDR_W-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
  end

endmodule
